// File: rtl/ppu_pkg.sv
// ppu_pkg: definitions shared between the PPU register block and the OAM DMA engine.
//   ppu_reg_t       - decode of the PPU register window. Includes DMA at 0xFF46.
//   OAM_BYTES_C     - number of sprite attribute bytes copied per DMA transfer.
//   dma_src_map()   - maps a DMA source page out of echo RAM into work RAM.
package ppu_pkg;

    typedef enum logic [15:0] {
        REG_LCDC = 16'hFF40,
        REG_STAT = 16'hFF41,
        REG_SCY  = 16'hFF42,
        REG_SCX  = 16'hFF43,
        REG_LY   = 16'hFF44,
        REG_LYC  = 16'hFF45,
        REG_DMA  = 16'hFF46,
        REG_BGP  = 16'hFF47,
        REG_OBP0 = 16'hFF48,
        REG_OBP1 = 16'hFF49,
        REG_WY   = 16'hFF4A,
        REG_WX   = 16'hFF4B
    } ppu_reg_t;

    localparam int OAM_BYTES_C       = 160;
    localparam int CYCLES_PER_BYTE_C = 4;
    localparam int START_DELAY_C     = 4;

    // Pages 0xE0..0xFF alias work RAM 0xC0..0xDF (echo RAM), so the read goes to the real copy.
    function automatic logic [7:0] dma_src_map(input logic [7:0] s);
        return (s >= 8'hE0) ? (s - 8'h20) : s;
    endfunction

endpackage

// File: rtl/oam_dma_m.sv
// oam_dma_m: OAM DMA engine. A write to the DMA register copies OAM_BYTES bytes
// from page S (after the echo remap) into OAM 0x00... The copy moves one byte
// every CYCLES_PER_BYTE clocks over the shared system bus.
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   reg_addr_i    register select, shared with the PPU register block
//   reg_write_i   register write strobe; starts a transfer when reg_addr_i == REG_DMA
//   reg_d_wr_i    register write data, the source page S
//   bus_read_o    one-clock read request on the system bus
//   bus_addr_o    read address {S', idx}
//   bus_d_rd_i    read data, valid exactly one clock after bus_read_o
//   oam_write_o   one-clock OAM write strobe
//   oam_addr_o    OAM byte index
//   oam_d_wr_o    OAM write data
//   busy_o        a transfer is pending or active; the CPU stalls non-HRAM accesses
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no transfer; waiting for a DMA register write
// ST_START | start delay; start_cnt_q counts down to zero
// ST_XFER  | byte idx_q in flight; phase 0 read, 1 capture, 2 OAM write
module oam_dma_m
    import ppu_pkg::*;
#(
    parameter int OAM_BYTES       = OAM_BYTES_C,
    parameter int CYCLES_PER_BYTE = CYCLES_PER_BYTE_C,
    parameter int START_DELAY     = START_DELAY_C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  ppu_reg_t    reg_addr_i,
    input  logic        reg_write_i,
    input  logic [7:0]  reg_d_wr_i,
    output logic        bus_read_o,
    output logic [15:0] bus_addr_o,
    input  logic [7:0]  bus_d_rd_i,
    output logic        oam_write_o,
    output logic [7:0]  oam_addr_o,
    output logic [7:0]  oam_d_wr_o,
    output logic        busy_o
);

    localparam int PH_W    = $clog2(CYCLES_PER_BYTE);
    localparam int START_W = $clog2(START_DELAY + 1);

    localparam logic [PH_W-1:0]    PH_CAPTURE = PH_W'(1);
    localparam logic [PH_W-1:0]    PH_LAST    = PH_W'(CYCLES_PER_BYTE - 1);
    localparam logic [7:0]         IDX_LAST   = 8'(OAM_BYTES - 1);
    localparam logic [START_W-1:0] START_LOAD = START_W'(START_DELAY - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_XFER  = 2'd2
    } dma_state_t;

    dma_state_t         state_q;
    logic [START_W-1:0] start_cnt_q;
    logic [PH_W-1:0]    phase_q;
    logic [7:0]         idx_q;
    logic [7:0]         src_q;
    logic               bus_read_q;
    logic [15:0]        bus_addr_q;
    logic               oam_write_q;
    logic [7:0]         oam_addr_q;
    logic [7:0]         oam_d_wr_q;
    logic               busy_q;

    logic dma_trig;
    assign dma_trig = reg_write_i && (reg_addr_i == REG_DMA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            start_cnt_q <= '0;
            phase_q     <= '0;
            idx_q       <= '0;
            src_q       <= '0;
            bus_read_q  <= 1'b0;
            bus_addr_q  <= '0;
            oam_write_q <= 1'b0;
            oam_addr_q  <= '0;
            oam_d_wr_q  <= '0;
            busy_q      <= 1'b0;
        end else if (dma_trig) begin
            // A trigger always restarts from the start delay, even in the middle of a transfer.
            // Clearing both strobes drops any byte that has not been issued yet.
            src_q       <= dma_src_map(reg_d_wr_i);
            state_q     <= ST_START;
            start_cnt_q <= START_LOAD;
            phase_q     <= '0;
            idx_q       <= '0;
            bus_read_q  <= 1'b0;
            oam_write_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    bus_read_q  <= 1'b0;
                    oam_write_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
                ST_START: begin
                    if (start_cnt_q == '0) begin
                        state_q    <= ST_XFER;
                        phase_q    <= '0;
                        idx_q      <= '0;
                        bus_read_q <= 1'b1;
                        bus_addr_q <= {src_q, 8'h00};
                    end else begin
                        start_cnt_q <= start_cnt_q - 1'b1;
                    end
                end
                ST_XFER: begin
                    bus_read_q  <= 1'b0;
                    oam_write_q <= 1'b0;
                    if (phase_q == PH_LAST) begin
                        phase_q <= '0;
                        if (idx_q == IDX_LAST) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            idx_q      <= idx_q + 8'd1;
                            bus_read_q <= 1'b1;
                            bus_addr_q <= {src_q, idx_q + 8'd1};
                        end
                    end else begin
                        phase_q <= phase_q + 1'b1;
                        // Read data is on the bus during phase 1. The OAM write is issued in phase 2.
                        if (phase_q == PH_CAPTURE) begin
                            oam_d_wr_q  <= bus_d_rd_i;
                            oam_write_q <= 1'b1;
                            oam_addr_q  <= idx_q;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    bus_read_q  <= 1'b0;
                    oam_write_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus_read_o  = bus_read_q;
    assign bus_addr_o  = bus_addr_q;
    assign oam_write_o = oam_write_q;
    assign oam_addr_o  = oam_addr_q;
    assign oam_d_wr_o  = oam_d_wr_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_oam_dma_m.sv
module tb_oam_dma_m;
    import ppu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    ppu_reg_t    reg_addr = REG_LCDC;
    logic        reg_write = 1'b0;
    logic [7:0]  reg_d_wr = 8'h00;
    logic        bus_read;
    logic [15:0] bus_addr;
    logic [7:0]  bus_d_rd = 8'h00;
    logic        oam_write;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_d_wr;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;
    int bus_mode = 0;
    logic [7:0] oam [0:159];

    oam_dma_m dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reg_addr_i (reg_addr),
        .reg_write_i(reg_write),
        .reg_d_wr_i (reg_d_wr),
        .bus_read_o (bus_read),
        .bus_addr_o (bus_addr),
        .bus_d_rd_i (bus_d_rd),
        .oam_write_o(oam_write),
        .oam_addr_o (oam_addr),
        .oam_d_wr_o (oam_d_wr),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    // Bus model: data is valid exactly one clock after the read request, and garbage otherwise.
    always @(posedge clk) begin
        if (bus_read) begin
            if (bus_mode == 0) bus_d_rd <= bus_addr[7:0] ^ 8'h5A;
            else               bus_d_rd <= bus_addr[15:8] + bus_addr[7:0];
        end else begin
            bus_d_rd <= 8'hEE;
        end
    end

    always @(posedge clk) begin
        if (oam_write && oam_addr < 8'd160) oam[oam_addr] <= oam_d_wr;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called at a negedge. The write is sampled at the following posedge (edge N).
    task automatic do_write(input ppu_reg_t a, input logic [7:0] d);
        reg_addr  = a;
        reg_d_wr  = d;
        reg_write = 1'b1;
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        reg_d_wr  = 8'h00;
    endtask

    // Samples at negedges t=1.. after edge N. Stops when busy is seen low or maxc is reached.
    task automatic watch(input int maxc, input logic [15:0] base,
                         output int t_done, output int t_rd0, output int t_wrl,
                         output int n_rd, output int n_wr, output int n_bad,
                         output int n_aerr, output logic busy1);
        logic prev_rd, prev_wr;
        prev_rd = 1'b0; prev_wr = 1'b0;
        t_done = -1; t_rd0 = -1; t_wrl = -1;
        n_rd = 0; n_wr = 0; n_bad = 0; n_aerr = 0; busy1 = 1'b0;
        for (int t = 1; t <= maxc; t++) begin
            @(negedge clk);
            if (t == 1) busy1 = busy;
            if (bus_read) begin
                if (t_rd0 < 0) t_rd0 = t;
                if (bus_addr !== base + 16'(n_rd)) n_aerr++;
                n_rd++;
            end
            if (oam_write) begin
                t_wrl = t;
                if (oam_addr !== 8'(n_wr)) n_aerr++;
                n_wr++;
            end
            if ((bus_read && oam_write) || (bus_read && prev_rd) || (oam_write && prev_wr)) n_bad++;
            prev_rd = bus_read;
            prev_wr = oam_write;
            if (!busy) begin
                t_done = t;
                break;
            end
        end
    endtask

    function automatic int oam_errs(input int mode, input logic [7:0] page);
        int e = 0;
        for (int k = 0; k < 160; k++) begin
            logic [7:0] exp;
            exp = (mode == 0) ? (8'(k) ^ 8'h5A) : (page + 8'(k));
            if (oam[k] !== exp) e++;
        end
        return e;
    endfunction

    initial begin
        int t_done, t_rd0, t_wrl, n_rd, n_wr, n_bad, n_aerr;
        logic busy1;
        int found;
        int quiet;

        // Reset
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_bus_read", bus_read, 0);
        chk("rst_oam_write", oam_write, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_oam_addr", oam_addr, 0);
        chk("rst_oam_d_wr", oam_d_wr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Tests 1 and 2: page 0xC0, data = addr[7:0]^0x5A
        bus_mode = 0;
        do_write(REG_DMA, 8'hC0);
        watch(2000, 16'hC000, t_done, t_rd0, t_wrl, n_rd, n_wr, n_bad, n_aerr, busy1);
        chk("t1_busy_at1", busy1, 1);
        chk("t1_first_read_t", t_rd0, 5);
        chk("t1_last_write_t", t_wrl, 643);
        chk("t1_busy_low_t", t_done, 645);
        chk("t1_last_oam_addr", oam_addr, 8'h9F);
        chk("t2_read_count", n_rd, 160);
        chk("t2_write_count", n_wr, 160);
        chk("t2_addr_seq_errs", n_aerr, 0);
        chk("t2_strobe_overlap", n_bad, 0);
        @(negedge clk);
        chk("t2_oam_content_errs", oam_errs(0, 8'h00), 0);

        // Test 3: echo page 0xE1 reads 0xC100..0xC19F
        do_write(REG_DMA, 8'hE1);
        watch(2000, 16'hC100, t_done, t_rd0, t_wrl, n_rd, n_wr, n_bad, n_aerr, busy1);
        chk("t3_read_count", n_rd, 160);
        chk("t3_addr_seq_errs", n_aerr, 0);
        chk("t3_busy_low_t", t_done, 645);

        // Test 4: retrigger with 0xD0 after byte 20 is written
        bus_mode = 1;
        do_write(REG_DMA, 8'hC0);
        found = 0;
        for (int i = 0; i < 1000 && found == 0; i++) begin
            @(negedge clk);
            if (oam_write && oam_addr == 8'd20) found = 1;
        end
        chk("t4_byte20_seen", found, 1);
        @(negedge clk);
        @(negedge clk);
        do_write(REG_DMA, 8'hD0);
        watch(2000, 16'hD000, t_done, t_rd0, t_wrl, n_rd, n_wr, n_bad, n_aerr, busy1);
        chk("t4_busy_held", busy1, 1);
        chk("t4_first_read_t", t_rd0, 5);
        chk("t4_busy_low_t", t_done, 645);
        chk("t4_write_count", n_wr, 160);
        chk("t4_addr_seq_errs", n_aerr, 0);
        chk("t4_strobe_overlap", n_bad, 0);
        @(negedge clk);
        chk("t4_oam_content_errs", oam_errs(1, 8'hD0), 0);

        // Test 5: reset pulse at +300 mid-transfer, then a normal transfer
        do_write(REG_DMA, 8'hC0);
        watch(299, 16'hC000, t_done, t_rd0, t_wrl, n_rd, n_wr, n_bad, n_aerr, busy1);
        chk("t5_still_busy", t_done, -1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_bus_read", bus_read, 0);
        chk("t5_rst_oam_write", oam_write, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy || bus_read || oam_write) quiet++;
        end
        chk("t5_quiet_after_rst", quiet, 0);
        do_write(REG_DMA, 8'hC8);
        watch(2000, 16'hC800, t_done, t_rd0, t_wrl, n_rd, n_wr, n_bad, n_aerr, busy1);
        chk("t5_busy_low_t", t_done, 645);
        chk("t5_write_count", n_wr, 160);
        chk("t5_addr_seq_errs", n_aerr, 0);
        @(negedge clk);
        chk("t5_oam_content_errs", oam_errs(1, 8'hC8), 0);

        // Test 6: writes to other registers do nothing
        do_write(REG_SCX, 8'hC0);
        quiet = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy || bus_read || oam_write) quiet++;
        end
        chk("t6_no_activity", quiet, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
